// File: rtl/digit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// digit_serial_adder_pkg
//
// Shared definitions for the digit-serial adder:
//   state_t    - controller states (IDLE, RUN, DONE)
//   SLICE_W    - width of one adder slice (one nibble per clock)
//   num_slices - number of slices needed to cover a given operand width
// -----------------------------------------------------------------------------
package digit_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
//
// 4-bit ripple carry adder built from a chain of full adders.
//
// Ports:
//   A, B  in  4  addends
//   Cin   in  1  carry in
//   Sum   out 4  A + B + Cin (low 4 bits)
//   Cout  out 1  carry out of bit 3
// -----------------------------------------------------------------------------
module ripple_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign Sum[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1]  = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end

    assign Cout = c[4];

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit
// ripple_carry_adder slice. The carry between nibbles lives in a register,
// so the combinational path is one 4-bit ripple plus the nibble select.
// An operation takes WIDTH/4 RUN cycles; the result is then held in DONE
// until the consumer takes it.
//
// Optional feature macro: DSA_OVF_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      operands present
//   in_ready  out  1      block can accept operands (IDLE only)
//   a, b      in   WIDTH  operands
//   cin       in   1      carry into the least-significant nibble
//   out_valid out  1      result present (DONE)
//   out_ready in   1      consumer takes result
//   sum       out  WIDTH  a + b + cin modulo 2^WIDTH
//   cout      out  1      carry out of the most-significant nibble
//   busy      out  1      high in RUN or DONE
//   ovf       out  1      signed overflow (only with DSA_OVF_EN)
// -----------------------------------------------------------------------------
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef DSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = num_slices(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("digit_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q, sum_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic                 cout_q;
    logic                 last_slice;

    logic [SLICE_W-1:0]   a_nib, b_nib, slice_sum;
    logic                 slice_cout;

    // Nibble select for the current slice
    assign a_nib = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign b_nib = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    ripple_carry_adder u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    assign last_slice = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, per-slice result write-back and carry chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_slice) begin
                        cout_q <= slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef DSA_OVF_EN
    logic ovf_q;
    logic msb_carry_in;

    // Carry into the MSB recovered from the top slice bit: c3 = a3 ^ b3 ^ s3
    assign msb_carry_in = a_nib[SLICE_W-1] ^ b_nib[SLICE_W-1] ^ slice_sum[SLICE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_slice) begin
            ovf_q <= msb_carry_in ^ slice_cout;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
